// File: rtl/ascon_round_iterator.sv
// ascon_round_iterator
//   Sequences one Ascon permutation (p12: rounds 0..11, p6: rounds 6..11)
//   around an external round datapath. The state register feeds state_o and
//   round_o downstream. The one-round result comes back on round_state_i and
//   is captured on every RUN cycle.
//
// State bus layout: {x0, x1, x2, x3, x4}, so x0 = [319:256] and x4 = [63:0].
//
// Ports
//   clock_i        in   1    rising-edge clock
//   reset_i        in   1    asynchronous, active-high reset
//   start_i        in   1    start a permutation on state_i (accepted in IDLE)
//   rounds6_i      in   1    sampled with start_i: 1 = p6, 0 = p12
//   state_i        in   320  initial permutation state
//   round_state_i  in   320  one-round result computed from state_o/round_o
//   abort_i        in   1    (ROUND_ITER_ABORT_EN only) abandon current run
//   round_o        out  4    current round index
//   state_o        out  320  state register
//   busy_o         out  1    high while a permutation runs
//   done_o         out  1    one-cycle pulse when the final state is on state_o
//
// Optional feature: define ROUND_ITER_ABORT_EN to add abort_i.
module ascon_round_iterator #(
  parameter logic [3:0] LAST_ROUND = 4'hB
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         rounds6_i,
  input  logic [319:0] state_i,
  input  logic [319:0] round_state_i,
`ifdef ROUND_ITER_ABORT_EN
  input  logic         abort_i,
`endif
  output logic [3:0]   round_o,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [319:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;
  logic         abort_w;

`ifdef ROUND_ITER_ABORT_EN
  assign abort_w = abort_i;
`else
  assign abort_w = 1'b0;
`endif

  // State register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      fsm_q   <= S_IDLE;
      state_q <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    round_d = round_q;
    done_d  = 1'b0;
    unique case (fsm_q)
      S_IDLE: begin
        // abort_i is ignored in IDLE; start_i alone decides.
        if (start_i) begin
          state_d = state_i;
          round_d = rounds6_i ? 4'd6 : 4'd0;
          fsm_d   = S_RUN;
        end
      end
      S_RUN: begin
        // Abort wins over round capture: state and round freeze where they are.
        if (abort_w) begin
          fsm_d = S_IDLE;
        end else begin
          state_d = round_state_i;
          if (round_q < LAST_ROUND) begin
            round_d = round_q + 4'd1;
          end else begin
            fsm_d  = S_IDLE;
            done_d = 1'b1;
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy_o  = (fsm_q == S_RUN);
    done_o  = done_q;
    state_o = state_q;
    round_o = round_q;
  end

endmodule
